// File: rtl/bp_stream_host_router_if.sv
// Host-side and channel-side stream bundle for bp_stream_host_router.
// Signal directions in the names are relative to the router.
interface bp_stream_host_router_if #(
  parameter int unsigned num_channels_p      = 2,
  parameter int unsigned stream_addr_width_p = 32,
  parameter int unsigned stream_data_width_p = 32,
  parameter int unsigned chan_width_p        = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
);
  // Host ingress stream
  logic                                          stream_v_i;
  logic [stream_addr_width_p-1:0]                stream_addr_i;
  logic [stream_data_width_p-1:0]                stream_data_i;
  logic                                          stream_yumi_o;
  // Per-channel ingress FIFO heads
  logic [num_channels_p-1:0]                     chan_v_o;
  logic [num_channels_p*stream_data_width_p-1:0] chan_data_o;
  logic [num_channels_p-1:0]                     chan_ready_i;
  // Per-channel return words
  logic [num_channels_p-1:0]                     chan_v_i;
  logic [num_channels_p*stream_data_width_p-1:0] chan_data_i;
  logic [num_channels_p-1:0]                     chan_yumi_o;
  // Host egress stream
  logic                                          stream_v_o;
  logic [stream_data_width_p-1:0]                stream_data_o;
  logic [chan_width_p-1:0]                       stream_chan_o;
  logic                                          stream_ready_i;

  modport slave (
    input  stream_v_i, stream_addr_i, stream_data_i, chan_ready_i, chan_v_i, chan_data_i,
           stream_ready_i,
    output stream_yumi_o, chan_v_o, chan_data_o, chan_yumi_o, stream_v_o, stream_data_o,
           stream_chan_o
  );

  modport master (
    output stream_v_i, stream_addr_i, stream_data_i, chan_ready_i, chan_v_i, chan_data_i,
           stream_ready_i,
    input  stream_yumi_o, chan_v_o, chan_data_o, chan_yumi_o, stream_v_o, stream_data_o,
           stream_chan_o
  );
endinterface

// File: rtl/bp_stream_host_router.sv
// Address-decoded host stream router with per-channel ingress FIFOs and a round-robin
// merged, registered return path tagged with the source channel.
module bp_stream_host_router #(
  parameter int unsigned                     num_channels_p      = 2,
  parameter int unsigned                     stream_addr_width_p = 32,
  parameter int unsigned                     stream_data_width_p = 32,
  parameter logic [stream_addr_width_p-1:0] base_addr_p         = 'h10,
  parameter int unsigned                     addr_stride_p       = 'h10,
  parameter int unsigned                     fifo_els_p          = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bp_stream_host_router_if.slave        host_io,
  input  logic                          err_clear_i,
  output logic [15:0]                   unmapped_cnt_o,
  output logic                          unmapped_err_o
);
  localparam int unsigned AW       = stream_addr_width_p;
  localparam int unsigned DW       = stream_data_width_p;
  localparam int unsigned ChanW    = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int unsigned PtrW     = $clog2(fifo_els_p);
  localparam int unsigned CntW     = $clog2(fifo_els_p + 1);
  localparam int unsigned StrideSh = $clog2(addr_stride_p);

  // Address decode
  logic [AW-1:0]             w_off;
  logic [AW-1:0]             w_idx_full;
  logic                      w_hit;
  logic [ChanW-1:0]          w_idx;
  logic                      w_tgt_full;
  logic                      w_accept;
  logic                      w_unmapped_acc;
  logic [num_channels_p-1:0] w_full;
  logic [num_channels_p-1:0] w_chan_v;

  assign w_off      = host_io.stream_addr_i - base_addr_p;
  assign w_idx_full = w_off >> StrideSh;
  assign w_hit      = (host_io.stream_addr_i >= base_addr_p)
                    && ((w_off & AW'(addr_stride_p - 1)) == '0)
                    && (w_idx_full < AW'(num_channels_p));
  assign w_idx      = w_idx_full[ChanW-1:0];

  always_comb begin
    w_tgt_full = 1'b0;
    for (int c = 0; c < int'(num_channels_p); c++) begin
      if (w_idx == ChanW'(c)) w_tgt_full = w_full[c];
    end
  end

  // Full comes from the registered count only, so chan_ready_i never reaches stream_yumi_o.
  assign w_accept       = reset_n_i & host_io.stream_v_i & (~w_hit | ~w_tgt_full);
  assign w_unmapped_acc = w_accept & ~w_hit;
  assign host_io.stream_yumi_o = w_accept;
  assign host_io.chan_v_o      = w_chan_v;

  for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
    logic [DW-1:0]   r_mem [fifo_els_p];
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [CntW-1:0] r_cnt;
    logic            w_push, w_pop;

    assign w_full[c]   = (r_cnt == CntW'(fifo_els_p));
    assign w_chan_v[c] = (r_cnt != '0);
    assign w_push      = w_accept & w_hit & (w_idx == ChanW'(c));
    assign w_pop       = w_chan_v[c] & host_io.chan_ready_i[c];
    assign host_io.chan_data_o[c*DW +: DW] = r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= (r_wptr == PtrW'(fifo_els_p - 1)) ? '0 : r_wptr + 1'b1;
        if (w_pop)  r_rptr <= (r_rptr == PtrW'(fifo_els_p - 1)) ? '0 : r_rptr + 1'b1;
        if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
        else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= host_io.stream_data_i;
    end
  end

  // Egress round-robin arbiter and output register
  logic             r_v;
  logic [DW-1:0]    r_data;
  logic [ChanW-1:0] r_chan;
  logic [ChanW-1:0] r_rr;
  logic             w_load;
  logic             w_any;
  logic [ChanW-1:0] w_grant;
  logic [ChanW-1:0] w_c;
  logic [DW-1:0]    w_sel_data;

  assign w_load = ~r_v | host_io.stream_ready_i;

  // Walk downward so the lowest offset from the pointer wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_c     = '0;
    for (int k = int'(num_channels_p) - 1; k >= 0; k--) begin
      w_c = ChanW'((int'(r_rr) + k) % int'(num_channels_p));
      if (host_io.chan_v_i[w_c]) begin
        w_any   = 1'b1;
        w_grant = w_c;
      end
    end
  end

  always_comb begin
    w_sel_data          = '0;
    host_io.chan_yumi_o = '0;
    for (int c = 0; c < int'(num_channels_p); c++) begin
      if (w_grant == ChanW'(c)) begin
        w_sel_data             = host_io.chan_data_i[c*DW +: DW];
        host_io.chan_yumi_o[c] = reset_n_i & w_load & w_any;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_chan <= '0;
      r_rr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_v    <= 1'b1;
        r_data <= w_sel_data;
        r_chan <= w_grant;
        r_rr   <= (w_grant == ChanW'(num_channels_p - 1)) ? '0 : w_grant + 1'b1;
      end else begin
        r_v <= 1'b0;
      end
    end
  end

  assign host_io.stream_v_o    = r_v;
  assign host_io.stream_data_o = r_data;
  assign host_io.stream_chan_o = r_chan;

  // Unmapped-write bookkeeping; a clear coinciding with a drop leaves exactly that one.
  logic [15:0] r_ucnt;
  logic        r_uerr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ucnt <= '0;
      r_uerr <= 1'b0;
    end else if (err_clear_i) begin
      r_ucnt <= {15'd0, w_unmapped_acc};
      r_uerr <= w_unmapped_acc;
    end else if (w_unmapped_acc) begin
      if (r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
      r_uerr <= 1'b1;
    end
  end

  assign unmapped_cnt_o = r_ucnt;
  assign unmapped_err_o = r_uerr;
endmodule

// File: doc/bp_stream_host_router.md
Name: bp_stream_host_router

Overview:
Parametrised successor to the two-target stream host front end. It routes an addressed host stream (e.g. AXI-Lite writes) to num_channels_p downstream consumers such as the NBF loader, MMIO and debug targets, with a per-channel ingress FIFO. Return streams from all channels are merged into one host-bound stream through a round-robin arbiter and a registered output stage; each returned word carries its channel tag. Unmapped host writes are consumed, counted and flagged instead of stalling the link.

Parameters:
num_channels_p, 2, number of downstream channels (1..8)
stream_addr_width_p, 32, host stream address width
stream_data_width_p, 32, host stream data width
base_addr_p, 32'h10, address of channel 0
addr_stride_p, 32'h10, address spacing between channels; power of two, >= 1
fifo_els_p, 4, ingress FIFO depth per channel (>= 2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
stream_v_i  in  1  host write valid
stream_addr_i  in  stream_addr_width_p  host write address
stream_data_i  in  stream_data_width_p  host write data
stream_yumi_o  out  1  host write consumed this cycle
chan_v_o  out  num_channels_p  per-channel ingress FIFO head valid
chan_data_o  out  num_channels_p*stream_data_width_p  per-channel head data; channel i occupies slice i
chan_ready_i  in  num_channels_p  per-channel consumer ready
chan_v_i  in  num_channels_p  per-channel return word valid
chan_data_i  in  num_channels_p*stream_data_width_p  per-channel return data
chan_yumi_o  out  num_channels_p  per-channel return word consumed
stream_v_o  out  1  host-bound word valid (registered)
stream_data_o  out  stream_data_width_p  host-bound data (registered)
stream_chan_o  out  max(1,$clog2(num_channels_p))  source channel of stream_data_o
stream_ready_i  in  1  host ready
unmapped_cnt_o  out  16  count of dropped unmapped writes, saturating
unmapped_err_o  out  1  sticky flag: at least one unmapped write seen
err_clear_i  in  1  synchronous clear of unmapped_cnt_o and unmapped_err_o

Behaviour:
- Reset (reset_n_i=0, asynchronous assert): all FIFOs empty, every chan_v_o=0, stream_v_o=0, stream_data_o=0, stream_chan_o=0, round-robin pointer=0, unmapped_cnt_o=0, unmapped_err_o=0. Outputs derived combinationally from inputs (stream_yumi_o, chan_yumi_o) are 0 whenever reset is asserted. Reset asserted mid-transfer discards all buffered words.
- Decode (combinational): off = stream_addr_i - base_addr_p. The write is a hit on channel idx = off/addr_stride_p when stream_addr_i >= base_addr_p, off mod addr_stride_p == 0 and idx < num_channels_p. Every other address is unmapped.
- Ingress accept: stream_yumi_o = stream_v_i & (unmapped | ~full[idx]). Full is taken from the registered FIFO count. A push into a full FIFO is blocked even if a pop occurs in the same cycle, so there is no path from chan_ready_i to stream_yumi_o.
- FIFO: chan_v_o[i] = ~empty[i]; chan_data_o slice i = head word. A pop occurs when chan_v_o[i] & chan_ready_i[i]. Push and pop in the same cycle on a non-full FIFO leave the count unchanged. Order is preserved per channel. Pointers wrap modulo fifo_els_p.
- Latency: an accepted write appears on chan_v_o the next cycle.
- Unmapped write: consumed the same cycle and its data dropped. unmapped_cnt_o increments and saturates at 16'hFFFF; unmapped_err_o is set.
- err_clear_i: clears the count and the flag. If an unmapped write is consumed in the same cycle, the result is cnt=1 and err=1.
- Egress output register: loads when stream_v_o=0 or (stream_v_o & stream_ready_i), so full throughput is one word per cycle.
  - On load with any chan_v_i set: grant g = first set bit searching from the RR pointer upward, modulo num_channels_p.
  - chan_yumi_o[g]=1; register <= {chan_data_i slice g, g}; stream_v_o=1 the next cycle; RR pointer <= (g+1) mod num_channels_p.
  - On load with no chan_v_i set: stream_v_o <= 0 and the pointer is unchanged.
- Egress latency: chan_v_i to stream_v_o is 1 cycle. While stream_v_o=1 and stream_ready_i=0, the register holds and all chan_yumi_o=0.
- chan_yumi_o is one-hot or zero, and each bit is only asserted when the matching chan_v_i is set.

Test Plan:
- Reset then idle: hold reset_n_i=0 with random inputs -> all outputs 0. Release, no stimulus -> chan_v_o=0, stream_v_o=0, unmapped_cnt_o=0.
- Routing (N=2): writes to 0x10 (0xA5A5A5A5) and 0x20 (0x5A5A5A5A), chan_ready_i=2'b11 -> each appears on chan_v_o[0] and chan_v_o[1] respectively, one cycle after yumi.
- Backpressure/full (fifo_els_p=4): 6 writes to 0x10 with chan_ready_i[0]=0 -> 4 accepted, then stream_yumi_o=0. Raise ready -> data 1..4 drained in order, the 5th is accepted only after the count drops.
- Unmapped: writes to 0x0, 0x18, 0x30 (N=2) -> each yumi'd immediately, none on chan_v_o, unmapped_cnt_o=3, err=1. err_clear_i together with a 4th unmapped write -> cnt=1, err=1.
- Round-robin: chan_v_i=2'b11 held, stream_ready_i=1 -> stream_chan_o alternates 0,1,0,1. With stream_ready_i=0 for 3 cycles -> word held stable and chan_yumi_o=0.
- Saturation: force 65537 unmapped writes -> unmapped_cnt_o=16'hFFFF, no wrap.
